// File: rtl/mul_arb.sv
// mul_arb: arbitrates N_REQ requesters onto one external signed Q8.8
// multiplier. Each accepted operand pair runs IDLE -> ISSUE -> CAPTURE -> RESP,
// and the result is returned to the requester that was granted.
//
// Optional feature macro: MUL_ARB_RR_EN
//   defined   : round-robin arbitration, search starts at a rotating pointer
//   undefined : fixed priority, lowest requester index wins
//
// Handshakes:
//   request  : pair i is taken on a rising edge where req_valid[i] and
//              req_ready[i] are both high; req_ready is one-hot and only
//              asserted in IDLE.
//   response : rsp_valid[tag] stays high with rsp_data stable until a rising
//              edge where rsp_ready[tag] is high; other rsp_ready bits are
//              ignored.
module mul_arb #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_data,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  output logic                 mul_start,
  input  logic [15:0]          mul_out,
  output logic                 busy,
  output logic [15:0]          op_count,
  output logic [1:0]           dbg_state
);

  localparam int TW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t         state;
  logic [TW-1:0]  tag;
  logic [TW-1:0]  win;
  logic           any_valid;
  logic [15:0]    a_arr [N_REQ];
  logic [15:0]    b_arr [N_REQ];

  // Operand buses viewed as per-requester words.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[16*g +: 16];
    assign b_arr[g] = req_b[16*g +: 16];
  end

`ifdef MUL_ARB_RR_EN
  logic [TW-1:0] ptr;

  // Round-robin winner: first valid requester at or after the pointer.
  always_comb begin
    int idx;
    win       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid && req_valid[TW'(idx)]) begin
        any_valid = 1'b1;
        win       = TW'(idx);
      end
    end
  end
`else
  // Fixed-priority winner: lowest valid index.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_valid && req_valid[TW'(k)]) begin
        any_valid = 1'b1;
        win       = TW'(k);
      end
    end
  end
`endif

  // Grant is combinational from the winner, only while idle and not in reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && any_valid) req_ready[win] = 1'b1;
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Sequencer: accept, strobe the multiplier, capture its result, hold the
  // response until the owning requester takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tag       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      op_count  <= '0;
`ifdef MUL_ARB_RR_EN
      ptr       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            mul_a     <= a_arr[win];
            mul_b     <= b_arr[win];
            tag       <= win;
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // The multiplier samples mul_a/mul_b on this edge.
          mul_start <= 1'b0;
          state     <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data  <= mul_out;
          rsp_valid <= N_REQ'(1) << tag;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[tag]) begin
            rsp_valid <= '0;
            op_count  <= op_count + 16'd1;
`ifdef MUL_ARB_RR_EN
            ptr       <= (tag == TW'(N_REQ - 1)) ? '0 : tag + 1'b1;
`endif
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a transaction-level model that
// tracks the in-flight operation by its age since acceptance.
module tb_mul_arb;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_a     = '0;
  logic [16*N-1:0] req_b     = '0;
  logic [N-1:0]    rsp_ready = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [15:0]     rsp_data;
  logic [15:0]     mul_a;
  logic [15:0]     mul_b;
  logic            mul_start;
  logic [15:0]     mul_out = '0;
  logic            busy;
  logic [15:0]     op_count;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q[$];

  mul_arb #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_out   (mul_out),
    .busy      (busy),
    .op_count  (op_count),
    .dbg_state (dbg_state)
  );

  // Signed Q8.8 product, truncated back to Q8.8.
  function automatic logic [15:0] q88_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  // External multiplier: result is ready the cycle after the strobe edge.
  always @(posedge clk) begin
    if (mul_start) mul_out <= q88_mul(mul_a, mul_b);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy = 0;
  int          m_age  = 0;
  int          m_tag  = 0;
  int          m_ptr  = 0;
  logic [15:0] m_last_a = '0;
  logic [15:0] m_last_b = '0;
  logic [15:0] m_data   = '0;
  logic [15:0] m_cnt    = '0;

  // Arbitration rule: first valid index searching upward from ptr (ptr is
  // always 0 in fixed-priority mode).
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int r;
    int i;
    r = -1;
    for (int k = 0; k < N; k++) begin
      i = (ptr + k) % N;
      if (r < 0 && v[i]) r = i;
    end
    return r;
  endfunction

  // Compare process: every cycle, check outputs against the model, then
  // advance the model by one cycle.
  always @(negedge clk) begin : cmp
    logic [N-1:0] e_ready;
    logic [N-1:0] e_rv;
    int w;
    if (rst) begin
      m_busy = 0; m_age = 0; m_tag = 0; m_ptr = 0;
      m_last_a = '0; m_last_b = '0; m_data = '0; m_cnt = '0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mul_start", mul_start, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_busy", busy, 0);
    end else begin
      e_ready = '0;
      e_rv    = '0;
      w = pick(req_valid, m_ptr);
      if (!m_busy && w >= 0) e_ready[w] = 1'b1;
      if (m_busy && m_age >= 3) e_rv[m_tag] = 1'b1;
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_data", rsp_data, m_data);
      chk("mul_a", mul_a, m_last_a);
      chk("mul_b", mul_b, m_last_b);
      chk("mul_start", mul_start, (m_busy && m_age == 1));
      chk("busy", busy, m_busy);
      chk("op_count", op_count, m_cnt);
      if (!m_busy) begin
        if (w >= 0) begin
          m_tag    = w;
          m_last_a = req_a[16*w +: 16];
          m_last_b = req_b[16*w +: 16];
          m_busy   = 1;
          m_age    = 1;
        end
      end else if (m_age >= 3) begin
        if (rsp_ready[m_tag]) begin
          m_busy = 0;
          m_cnt  = m_cnt + 16'd1;
`ifdef MUL_ARB_RR_EN
          m_ptr  = (m_tag + 1) % N;
`endif
        end
      end else begin
        if (m_age == 2) m_data = q88_mul(m_last_a, m_last_b);
        m_age++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = '0;
    smp();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    smp();
    while (busy && c < 20) begin
      tick();
      smp();
      c++;
    end
    if (busy) chk({name, "_idle_timeout"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : drv
    int got;
    repeat (2) tick();
    rst = 1'b0;

    // Single requester 0: 1.5 * 2.0 = 3.0
    tick();
    req_valid = 4'b0001; req_a[15:0] = 16'h0180; req_b[15:0] = 16'h0200;
    rsp_ready = 4'b1111;
    smp(); chk("t1_req_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    smp(); chk("t1_mul_start", mul_start, 1); chk("t1_mul_a", mul_a, 16'h0180);
    tick(); smp(); chk("t1_no_rsp_yet", rsp_valid, 0);
    tick(); smp(); chk("t1_rsp_valid", rsp_valid, 4'b0001); chk("t1_rsp_data", rsp_data, 16'h0300);
    tick(); smp(); chk("t1_op_count", op_count, 1); chk("t1_idle", busy, 0);

    // Negative operand on requester 2: -1.0 * 2.0 = -2.0
    tick();
    req_valid = 4'b0100; req_a[47:32] = 16'hFF00; req_b[47:32] = 16'h0200;
    smp(); chk("t2_req_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    tick(); tick();
    smp(); chk("t2_rsp_valid", rsp_valid, 4'b0100); chk("t2_rsp_data", rsp_data, 16'hFE00);
    tick();

    // All requesters pending: grant order
    do_reset();
`ifdef MUL_ARB_RR_EN
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
`else
    repeat (5) exp_q.push_back(4'b0001);
`endif
    req_valid = '1; rsp_ready = '1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      smp();
      if (|req_ready) begin
        chk("t3_grant", req_ready, exp_q.pop_front());
        got++;
      end
      tick();
    end
    if (got < 5) chk("t3_grant_timeout", got, 5);
    req_valid = '0;
    wait_idle("t3");

    // Backpressure on requester 1: 2.25 * -1.5 = -3.375
    tick();
    req_valid = 4'b0010; req_a[31:16] = 16'h0240; req_b[31:16] = 16'hFE80;
    rsp_ready = 4'b0001;
    smp(); chk("t4_req_ready", req_ready, 4'b0010);
    tick(); req_valid = '1;
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("t4_hold_rsp_valid", rsp_valid, 4'b0010);
      chk("t4_hold_rsp_data", rsp_data, 16'hFCA0);
      chk("t4_hold_busy", busy, 1);
      chk("t4_hold_no_grant", req_ready, 0);
      tick();
    end
    rsp_ready = 4'b0010; req_valid = '0;
    smp(); chk("t4_release_rsp_valid", rsp_valid, 4'b0010);
    tick(); smp(); chk("t4_release_idle", busy, 0);

    // Reset during CAPTURE, then during ISSUE, then a normal operation
    do_reset();
    rsp_ready = '1;
    req_a[15:0] = 16'h0100; req_b[15:0] = 16'h0300;
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick(); rst = 1'b1;
    smp();
    chk("t5_rst_rsp_valid", rsp_valid, 0); chk("t5_rst_op_count", op_count, 0);
    chk("t5_rst_busy", busy, 0); chk("t5_rst_mul_a", mul_a, 0);
    tick(); rst = 1'b0;
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    smp(); chk("t5_issue_mul_start", mul_start, 1);
    #2; rst = 1'b1;
    #1; chk("t5_rst_mul_start_now", mul_start, 0);
    tick(); smp();
    tick(); rst = 1'b0;
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick(); tick();
    smp(); chk("t5_after_rsp_valid", rsp_valid, 4'b0001); chk("t5_after_rsp_data", rsp_data, 16'h0300);
    tick(); smp(); chk("t5_after_op_count", op_count, 1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      tick();
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = N'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 199) == 0);
    end
    tick();
    rst = 1'b0; req_valid = '0; rsp_ready = '1;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
